// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the write-back stage: data width, result
//               select encoding, load funct3 codes and the stage entry record.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_WIDTH = 64;

  // Result select carried with each beat; the last code is reserved.
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_t;

  // Load funct3 codes (bit 2 = zero-extend, bits 1:0 = log2 of size).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // One buffered beat: write request plus its already-final data.
  typedef struct packed {
    logic                  valid;
    logic [4:0]            rd;
    logic                  rd_we;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if
// Description : Upstream (MEM -> WB) beat handshake bundle.
// Signals     : in_valid/in_ready handshake, in_rd/in_rd_we destination,
//               in_sel result select, in_alu_result/in_pc/in_load_raw data,
//               in_funct3/in_addr_lo load size and byte offset.
// Modports    : master (producer, MEM side), slave (write-back stage).
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if;
  import cpu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_rd;
  logic                  in_rd_we;
  logic [1:0]            in_sel;
  logic [DATA_WIDTH-1:0] in_alu_result;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_load_raw;
  logic [2:0]            in_funct3;
  logic [2:0]            in_addr_lo;

  modport master (
    output in_valid, in_rd, in_rd_we, in_sel, in_alu_result, in_pc,
           in_load_raw, in_funct3, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_rd_we, in_sel, in_alu_result, in_pc,
           in_load_raw, in_funct3, in_addr_lo,
    output in_ready
  );

endinterface : wb_stage_if
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational load lane select and sign/zero extension from
//               an aligned 64-bit doubleword.
// Ports       : raw_i     - raw memory doubleword
//               funct3_i  - load size/sign code
//               addr_lo_i - byte offset inside the doubleword
//               data_o    - extended load result (0 for funct3 3'b111)
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
  import cpu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic [2:0]            funct3_i,
  input  logic [2:0]            addr_lo_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [2:0]            off;
  logic [DATA_WIDTH-1:0] lane;

  // Offset bits below the access size are ignored (forced aligned).
  always_comb begin
    off = addr_lo_i;
    case (funct3_i[1:0])
      2'b01:   off = {addr_lo_i[2:1], 1'b0};
      2'b10:   off = {addr_lo_i[2], 2'b00};
      2'b11:   off = 3'b000;
      default: off = addr_lo_i;
    endcase
  end

  // Bring the selected lane down to bit 0.
  assign lane = raw_i >> {off, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
      F3_LH:   data_o = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      F3_LW:   data_o = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
      F3_LD:   data_o = lane;
      F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}},      lane[7:0]};
      F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}},     lane[15:0]};
      F3_LWU:  data_o = {{(DATA_WIDTH-32){1'b0}},     lane[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage with an output entry and a skid entry.
//               Final data is formed at capture; the output entry drives the
//               register-file write port and both entries drive bypasses.
// Ports       : clk, rst (async, active-low)
//               up         - upstream beat bundle (slave side)
//               w_hold     - downstream freeze, blocks retirement
//               w_addr/w_data/w_ena - register-file write port
//               fwd0_*     - bypass from the output entry
//               fwd1_*     - bypass from the skid entry (younger)
//               retire_cnt - number of retired beats (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  wb_stage_if.slave             up,
  input  logic                  w_hold,
  output logic [4:0]            w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ena,
  output logic                  fwd0_valid,
  output logic [4:0]            fwd0_addr,
  output logic [DATA_WIDTH-1:0] fwd0_data,
  output logic                  fwd1_valid,
  output logic [4:0]            fwd1_addr,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] retire_cnt
);

  wb_entry_t             ob_q, ob_d;
  wb_entry_t             sb_q, sb_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] cap_data;
  wb_entry_t             cap;
  logic                  drain;
  logic                  accept;
  logic                  ob_wr;

  load_ext u_load_ext (
    .raw_i     (up.in_load_raw),
    .funct3_i  (up.in_funct3),
    .addr_lo_i (up.in_addr_lo),
    .data_o    (load_data)
  );

  always_comb begin
    cap_data = '0;
    case (wb_sel_t'(up.in_sel))
      WB_SEL_ALU:  cap_data = up.in_alu_result;
      WB_SEL_LOAD: cap_data = load_data;
      WB_SEL_PC4:  cap_data = up.in_pc + DATA_WIDTH'(4);
      default:     cap_data = '0;
    endcase
  end

  always_comb begin
    cap       = '0;
    cap.valid = 1'b1;
    cap.rd    = up.in_rd;
    cap.rd_we = up.in_rd_we;
    cap.data  = cap_data;
  end

  // Readiness depends on registered state only, so w_hold never reaches
  // in_ready combinationally.
  assign up.in_ready = !sb_q.valid;
  assign drain       = ob_q.valid && !w_hold;
  assign accept      = up.in_valid && up.in_ready;

  always_comb begin
    ob_d  = ob_q;
    sb_d  = sb_q;
    cnt_d = cnt_q;
    if (drain) begin
      cnt_d = cnt_q + DATA_WIDTH'(1);
    end
    if (drain || !ob_q.valid) begin
      // Skid entry is older than any incoming beat, so it refills first.
      if (sb_q.valid) begin
        ob_d       = sb_q;
        sb_d.valid = 1'b0;
      end else if (accept) begin
        ob_d = cap;
      end else begin
        ob_d.valid = 1'b0;
      end
    end else if (accept) begin
      // Output entry is frozen by w_hold: park the new beat in the skid.
      sb_d = cap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_q  <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ob_q  <= ob_d;
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  // x0 is never written or forwarded.
  assign ob_wr      = ob_q.valid && ob_q.rd_we && (ob_q.rd != 5'd0);

  assign w_ena      = ob_wr && !w_hold;
  assign w_addr     = ob_q.rd;
  assign w_data     = ob_q.data;

  assign fwd0_valid = ob_wr;
  assign fwd0_addr  = ob_q.rd;
  assign fwd0_data  = ob_q.data;

  assign fwd1_valid = sb_q.valid && sb_q.rd_we && (sb_q.rd != 5'd0);
  assign fwd1_addr  = sb_q.rd;
  assign fwd1_data  = sb_q.data;

  assign retire_cnt = cnt_q;

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage. A queue-based model of the
//               beats held in the stage is compared against the DUT outputs
//               every cycle; directed beats pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        w_hold;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic        w_ena;
  logic        fwd0_valid, fwd1_valid;
  logic [4:0]  fwd0_addr, fwd1_addr;
  logic [63:0] fwd0_data, fwd1_data;
  logic [63:0] retire_cnt;

  wb_stage_if bus ();

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .up         (bus),
    .w_hold     (w_hold),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_ena      (w_ena),
    .fwd0_valid (fwd0_valid),
    .fwd0_addr  (fwd0_addr),
    .fwd0_data  (fwd0_data),
    .fwd1_valid (fwd1_valid),
    .fwd1_addr  (fwd1_addr),
    .fwd1_data  (fwd1_data),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
  } beat_t;

  beat_t       pend[$];
  logic [63:0] mcnt = '0;

  function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [2:0] f3,
                                             input logic [2:0] lo);
    int          size;
    int          base;
    logic [63:0] v;
    logic [63:0] mask;
    if (f3 == 3'b111) return 64'd0;
    size = 1 << f3[1:0];
    base = int'(lo) - (int'(lo) % size);
    v = '0;
    for (int i = 0; i < size; i++)
      v = v | (((raw >> (8 * (base + i))) & 64'hFF) << (8 * i));
    if (size < 8) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [63:0] model_data(input logic [1:0] sel, input logic [63:0] alu,
                                             input logic [63:0] pc, input logic [63:0] raw,
                                             input logic [2:0] f3, input logic [2:0] lo);
    case (sel)
      2'd0:    return alu;
      2'd1:    return model_load(raw, f3, lo);
      2'd2:    return pc + 64'd4;
      default: return 64'd0;
    endcase
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    logic  e_ena, e_f0, e_f1, acc, drn;
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        mcnt = '0;
      end
      e_f0  = pend.size() > 0 && pend[0].we && pend[0].rd != 5'd0;
      e_f1  = pend.size() > 1 && pend[1].we && pend[1].rd != 5'd0;
      e_ena = e_f0 && !w_hold;
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, pend.size() < 2});
      check("w_ena", {63'd0, w_ena}, {63'd0, e_ena});
      if (e_ena) begin
        check("w_addr", {59'd0, w_addr}, {59'd0, pend[0].rd});
        check("w_data", w_data, pend[0].data);
      end
      check("fwd0_valid", {63'd0, fwd0_valid}, {63'd0, e_f0});
      if (e_f0) begin
        check("fwd0_addr", {59'd0, fwd0_addr}, {59'd0, pend[0].rd});
        check("fwd0_data", fwd0_data, pend[0].data);
      end
      check("fwd1_valid", {63'd0, fwd1_valid}, {63'd0, e_f1});
      if (e_f1) begin
        check("fwd1_addr", {59'd0, fwd1_addr}, {59'd0, pend[1].rd});
        check("fwd1_data", fwd1_data, pend[1].data);
      end
      check("retire_cnt", retire_cnt, mcnt);

      @(posedge clk);
      if (!rst) begin
        pend.delete();
        mcnt = '0;
      end else begin
        acc = bus.in_valid && pend.size() < 2;
        drn = pend.size() > 0 && !w_hold;
        if (drn) begin
          void'(pend.pop_front());
          mcnt = mcnt + 64'd1;
        end
        if (acc) begin
          b.rd   = bus.in_rd;
          b.we   = bus.in_rd_we;
          b.data = model_data(bus.in_sel, bus.in_alu_result, bus.in_pc, bus.in_load_raw,
                              bus.in_funct3, bus.in_addr_lo);
          pend.push_back(b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_hold = 1'b0;

  // Present a beat and hold it until it transfers; returns #1 after the
  // accepting edge.
  task automatic send_beat(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                           input logic [63:0] alu, input logic [63:0] pc,
                           input logic [63:0] raw, input logic [2:0] f3,
                           input logic [2:0] lo);
    bit ok;
    bus.in_valid      = 1'b1;
    bus.in_rd         = rd;
    bus.in_rd_we      = we;
    bus.in_sel        = sel;
    bus.in_alu_result = alu;
    bus.in_pc         = pc;
    bus.in_load_raw   = raw;
    bus.in_funct3     = f3;
    bus.in_addr_lo    = lo;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (rand_hold) w_hold = ($urandom_range(0, 3) == 0);
    end
    bus.in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b0;
    w_hold            = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_rd         = '0;
    bus.in_rd_we      = 1'b0;
    bus.in_sel        = '0;
    bus.in_alu_result = '0;
    bus.in_pc         = '0;
    bus.in_load_raw   = '0;
    bus.in_funct3     = '0;
    bus.in_addr_lo    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_w_ena", {63'd0, w_ena}, 64'd0);
    check("rst_cnt", retire_cnt, 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // ALU beat
    send_beat(5'd5, 1'b1, 2'd0, 64'h1234, 64'd0, 64'd0, 3'd0, 3'd0);
    check("alu_w_ena", {63'd0, w_ena}, 64'd1);
    check("alu_w_addr", {59'd0, w_addr}, 64'd5);
    check("alu_w_data", w_data, 64'h1234);
    step();
    check("alu_cnt", retire_cnt, 64'd1);

    // LB / LBU at byte offset 1
    send_beat(5'd3, 1'b1, 2'd1, 64'd0, 64'd0, 64'h80FF, F3_LB, 3'd1);
    check("lb_data", w_data, 64'hFFFF_FFFF_FFFF_FF80);
    send_beat(5'd3, 1'b1, 2'd1, 64'd0, 64'd0, 64'h80FF, F3_LBU, 3'd1);
    check("lbu_data", w_data, 64'h80);
    step();

    // x0 destination: no write, no bypass, still retires
    send_beat(5'd0, 1'b1, 2'd0, 64'hDEAD, 64'd0, 64'd0, 3'd0, 3'd0);
    check("x0_w_ena", {63'd0, w_ena}, 64'd0);
    check("x0_fwd0", {63'd0, fwd0_valid}, 64'd0);
    step();
    check("x0_cnt", retire_cnt, 64'd4);

    // Hold with OB full: second beat lands in the skid entry
    w_hold = 1'b1;
    send_beat(5'd7, 1'b1, 2'd0, 64'hA, 64'd0, 64'd0, 3'd0, 3'd0);
    send_beat(5'd9, 1'b1, 2'd0, 64'hB, 64'd0, 64'd0, 3'd0, 3'd0);
    check("skid_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("skid_fwd1_v", {63'd0, fwd1_valid}, 64'd1);
    check("skid_fwd1_a", {59'd0, fwd1_addr}, 64'd9);
    check("skid_fwd1_d", fwd1_data, 64'hB);
    check("skid_fwd0_a", {59'd0, fwd0_addr}, 64'd7);
    check("skid_w_ena", {63'd0, w_ena}, 64'd0);
    w_hold = 1'b0;
    #1;
    check("rel_a_ena", {63'd0, w_ena}, 64'd1);
    check("rel_a_addr", {59'd0, w_addr}, 64'd7);
    check("rel_a_data", w_data, 64'hA);
    step();
    check("rel_b_ena", {63'd0, w_ena}, 64'd1);
    check("rel_b_addr", {59'd0, w_addr}, 64'd9);
    check("rel_b_data", w_data, 64'hB);
    check("rel_b_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    check("rel_empty", {63'd0, w_ena}, 64'd0);
    check("rel_cnt", retire_cnt, 64'd6);

    // PC+4 wraps modulo 2^64
    send_beat(5'd1, 1'b1, 2'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 3'd0, 3'd0);
    check("pc4_data", w_data, 64'd2);
    step();
    check("pc4_cnt", retire_cnt, 64'd7);

    // Asynchronous reset with both entries full
    w_hold = 1'b1;
    send_beat(5'd11, 1'b1, 2'd0, 64'hC, 64'd0, 64'd0, 3'd0, 3'd0);
    send_beat(5'd12, 1'b1, 2'd0, 64'hD, 64'd0, 64'd0, 3'd0, 3'd0);
    check("full_fwd1_v", {63'd0, fwd1_valid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_w_ena", {63'd0, w_ena}, 64'd0);
    check("arst_ready", {63'd0, bus.in_ready}, 64'd1);
    check("arst_cnt", retire_cnt, 64'd0);
    check("arst_fwd0", {63'd0, fwd0_valid}, 64'd0);
    check("arst_fwd1", {63'd0, fwd1_valid}, 64'd0);
    w_hold = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) step();
    check("post_rst_w_ena", {63'd0, w_ena}, 64'd0);
    check("post_rst_cnt", retire_cnt, 64'd0);

    // 100 random beats with random hold
    rand_hold = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        step();
        w_hold = ($urandom_range(0, 3) == 0);
      end
      send_beat(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    rand_hold = 1'b0;
    w_hold    = 1'b0;
    repeat (4) step();
    check("rand_cnt", retire_cnt, 64'd100);
    check("rand_empty", {63'd0, w_ena}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire
